registers_reader: RTL and testbench
===================================

REGISTERS_READER -- requirements
Module: registers_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register word width.
REQ-002 SHALL have parameter N_THREADS, default 6, thread count of the register file.
REQ-003 SHALL have parameter N_THREADS_MSB, default `MSB(N_THREADS-1), MSB of the thread number.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a burst read; sampled only in IDLE.
REQ-007 SHALL have port thread_num  input  N_THREADS_MSB+1  thread to read; captured on start.
REQ-008 SHALL have port start_addr  input  `REG_ADDR_MSB+1  first register address; captured on start.
REQ-009 SHALL have port count  input  5  number of registers to read (0..16); captured on start.
REQ-010 SHALL have port busy  output  1  high from accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-012 SHALL have port rd_addr  output  `REG_ADDR_MSB+1  register address to the register file.
REQ-013 SHALL have port rd_thread_num  output  N_THREADS_MSB+1  thread number to the register file.
REQ-014 SHALL have port rd_en0  output  1  register-file array read enable.
REQ-015 SHALL have port rd_en1  output  1  register-file output flop enable.
REQ-016 SHALL have port reg_dout  input  WIDTH  register-file read data.
REQ-017 SHALL have ports out_data (output, WIDTH), out_valid (output, 1), out_ready (input, 1), out_last (output, 1): output stream.

Function
REQ-018 SHALL have states IDLE, READ, DRAIN; IDLE->READ on start with count!=0; READ->DRAIN when the last read is issued; DRAIN->IDLE when the last word is accepted (out_valid & out_ready & out_last).
REQ-019 SHALL, on start with count==0, stay in IDLE, issue no reads, and pulse done on the next cycle.
REQ-020 SHALL produce register-file read timing: rd_en0 at cycle t, rd_en1 at cycle t+1 (exactly rd_en0 delayed one cycle), with reg_dout valid and captured at cycle t+2.
REQ-021 SHALL hold rd_thread_num constant for the whole burst; rd_addr SHALL increment by 1 per issued read, modulo 16 (address 15 wraps to 0 within the same thread).
REQ-022 SHALL buffer captured words in a 4-entry output FIFO, in issue order.
REQ-023 SHALL issue a read only while (FIFO occupancy + reads in flight) < 4, so no captured word is ever dropped under any out_ready pattern.
REQ-024 SHALL sustain one word per cycle when out_ready is held high; first out_valid no earlier than 3 cycles after the accepted start.
REQ-025 SHALL present out_valid=1 when the FIFO is non-empty; out_data/out_last SHALL stay stable while out_valid & !out_ready.
REQ-026 SHALL assert out_last only with the count-th word of the burst.
REQ-027 SHALL ignore start while busy; parameters of the running burst SHALL not change.
REQ-028 SHALL assert done exactly one cycle after the last-word handshake, with busy falling in the same cycle as done; a new start SHALL be accepted in the cycle done is high.

Reset
REQ-029 SHALL, while reset is high, drive busy=0, done=0, rd_en0=0, rd_en1=0, out_valid=0, out_last=0, rd_addr=0, rd_thread_num=0, and state IDLE.
REQ-030 SHALL, on reset mid-burst, abandon the burst, empty the FIFO, discard in-flight reads and not pulse done.

Verification
REQ-031 SHALL be verified: start, thread 2, addr 3, count 5, out_ready=1 -> rd_addr 3,4,5,6,7 on consecutive cycles, words {2,3}..{2,7} in order, out_last on 5th, done one cycle later.
REQ-032 SHALL be verified: addr 14, count 4 -> rd_addr 14,15,0,1 within the same thread; out_last on register 1.
REQ-033 SHALL be verified: count 16, out_ready toggled randomly / held low 20 cycles -> all 16 words delivered exactly once, in order, reads stall at 4 outstanding.
REQ-034 SHALL be verified: count 0 -> no rd_en0, no out_valid, done pulse one cycle after start.
REQ-035 SHALL be verified: reset asserted at 3rd word of 8-word burst -> out_valid=0, busy=0 next cycle, no done; following burst correct.
REQ-036 SHALL be verified: start held during a burst and again in the done cycle -> first ignored, second begins a new burst.

Source files
------------

// File: rtl/registers_reader_if.sv
// Output stream of the registers_reader burst engine.
//   out_data  : register word, valid with out_valid
//   out_valid : a word is presented
//   out_ready : the consumer accepts the word this cycle
//   out_last  : presented word is the final word of the burst
// master = producer (registers_reader), slave = consumer.
interface registers_reader_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/registers_reader.sv
// registers_reader: burst reader for a multithreaded register file.
// On start it reads 'count' consecutive registers (address wraps modulo 16)
// of one thread and streams the words out through a 4-entry FIFO.
// Ports:
//   CLK, reset        : clock (rising edge), synchronous active-high reset
//   start             : burst request, sampled only while idle
//   thread_num        : thread to read, captured on start
//   start_addr        : first register address, captured on start
//   count             : number of registers (0..16), captured on start
//   busy, done        : burst in progress / one-cycle completion pulse
//   rd_addr           : register address to the register file
//   rd_thread_num     : thread number to the register file
//   rd_en0, rd_en1    : array read enable / output flop enable (en0 delayed)
//   reg_dout          : register-file data, valid two cycles after rd_en0
//   out               : output stream (master side)
`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

module registers_reader #(
   parameter int WIDTH         = 16,
   parameter int N_THREADS     = 6,
   parameter int N_THREADS_MSB = `MSB(N_THREADS-1)
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     start,
   input  logic [N_THREADS_MSB:0]   thread_num,
   input  logic [`REG_ADDR_MSB:0]   start_addr,
   input  logic [4:0]               count,
   output logic                     busy,
   output logic                     done,
   output logic [`REG_ADDR_MSB:0]   rd_addr,
   output logic [N_THREADS_MSB:0]   rd_thread_num,
   output logic                     rd_en0,
   output logic                     rd_en1,
   input  logic [WIDTH-1:0]         reg_dout,
   registers_reader_if.master       out
);

   localparam int STAGES = 2;    // rd_en0 -> rd_en1 -> data on reg_dout
   localparam int DEPTH  = 4;
   localparam logic [`REG_ADDR_MSB:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t              state;
   logic [STAGES:0]     vld_pipe;   // [0]=array read, [1]=output flop, [2]=reg_dout valid
   logic [STAGES:0]     last_pipe;  // tags the final read as it travels
   logic [4:0]          remaining;  // reads still to issue after the current one

   logic [WIDTH-1:0]    fifo_data [DEPTH];
   logic [DEPTH-1:0]    fifo_last;
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic [2:0]          occ;

   logic                push;
   logic                pop;
   logic [3:0]          outstanding;
   logic                can_issue;

   assign rd_en0 = vld_pipe[0];
   assign rd_en1 = vld_pipe[1];

   assign out.out_valid = (occ != 3'd0);
   assign out.out_data  = fifo_data[rd_ptr];
   assign out.out_last  = out.out_valid & fifo_last[rd_ptr];

   assign push = vld_pipe[STAGES];
   assign pop  = out.out_valid & out.out_ready;

   // Every word in the pipe lands in the FIFO, so FIFO words plus reads in
   // flight must never exceed the FIFO depth. The current cycle's pop frees
   // one slot before the next read would enter the pipe.
   assign outstanding = {1'b0, occ} + {3'b0, vld_pipe[0]} + {3'b0, vld_pipe[1]}
                      + {3'b0, vld_pipe[2]};
   assign can_issue   = (outstanding - {3'b0, pop}) < 4'(DEPTH);

   // Control FSM, read issue and FIFO bookkeeping.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         rd_addr       <= '0;
         rd_thread_num <= '0;
         remaining     <= '0;
         vld_pipe      <= '0;
         last_pipe     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occ           <= '0;
      end else begin
         done                  <= 1'b0;
         vld_pipe[STAGES:1]    <= vld_pipe[STAGES-1:0];
         last_pipe[STAGES:1]   <= last_pipe[STAGES-1:0];
         vld_pipe[0]           <= 1'b0;
         last_pipe[0]          <= 1'b0;

         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         occ <= occ + {2'b0, push} - {2'b0, pop};

         case (state)
            IDLE: begin
               if (start) begin
                  if (count == 5'd0) begin
                     done <= 1'b1;
                  end else begin
                     // Pipe and FIFO are empty here, so the first read
                     // goes out immediately.
                     busy          <= 1'b1;
                     rd_thread_num <= thread_num;
                     rd_addr       <= start_addr;
                     vld_pipe[0]   <= 1'b1;
                     last_pipe[0]  <= (count == 5'd1);
                     remaining     <= count - 5'd1;
                     state         <= (count == 5'd1) ? DRAIN : READ;
                  end
               end
            end
            READ: begin
               if (can_issue) begin
                  rd_addr      <= rd_addr + ADDR_ONE;   // wraps inside the thread
                  vld_pipe[0]  <= 1'b1;
                  last_pipe[0] <= (remaining == 5'd1);
                  remaining    <= remaining - 5'd1;
                  if (remaining == 5'd1) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && out.out_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage; contents are qualified by occ, so no reset needed.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_data[wr_ptr] <= reg_dout;
         fifo_last[wr_ptr] <= last_pipe[STAGES];
      end
   end

endmodule

// File: tb/tb_registers_reader.sv
module tb_registers_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  thread_num;
   logic [3:0]  start_addr;
   logic [4:0]  count;
   logic        busy, done;
   logic [3:0]  rd_addr;
   logic [2:0]  rd_thread_num;
   logic        rd_en0, rd_en1;
   logic [15:0] reg_dout;

   registers_reader_if #(.WIDTH(16)) out_if ();

   registers_reader dut (
      .CLK(clk), .reset(rst), .start(start), .thread_num(thread_num),
      .start_addr(start_addr), .count(count), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_thread_num(rd_thread_num), .rd_en0(rd_en0),
      .rd_en1(rd_en1), .reg_dout(reg_dout), .out(out_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // register contents: {thread, address}
   function automatic logic [15:0] word(input int t, input int a);
      return {t[7:0], a[7:0]};
   endfunction

   // register file: array read on rd_en0, output flop on rd_en1; reg_dout is
   // garbage in any cycle not loaded, so only the t+2 capture is correct
   logic [15:0] arr_q;
   always @(posedge clk) begin
      if (rd_en0) arr_q <= word(int'(rd_thread_num), int'(rd_addr));
      if (rd_en1) reg_dout <= arr_q;
      else        reg_dout <= 16'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   bit   m_busy = 0, m_done = 0, m_after_rst = 0, m_first = 0, sustain = 0;
   int   m_thread, m_saddr, m_addr, m_count, m_issued = 0, m_delivered = 0;
   int   m_accept_cyc, cyc = 0, n_accept = 0, n_done = 0, n_valid = 0, n_en0 = 0;
   int   done_cyc, last_hs_cyc;
   bit   prev_en0 = 0, prev_stall = 0, prev_last = 0;
   logic [15:0] prev_data;
   int          got_addrs[$];
   int          issue_cyc[$];
   logic [15:0] got_words[$];

   always @(negedge clk) begin
      bit hs_last;
      hs_last = 0;
      cyc++;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) begin n_done++; done_cyc = cyc; end
      if (m_after_rst) begin
         chk("rst_en0", rd_en0, 0);  chk("rst_en1", rd_en1, 0);
         chk("rst_valid", out_if.out_valid, 0); chk("rst_last", out_if.out_last, 0);
         chk("rst_addr", rd_addr, 0); chk("rst_thread", rd_thread_num, 0);
      end else begin
         chk("en1_delay", rd_en1, prev_en0);
      end
      if (rd_en0) begin
         n_en0++;
         if (!m_busy) chk("en0_idle", rd_en0, 0);
         else begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_thread", rd_thread_num, m_thread);
            m_issued++;
            got_addrs.push_back(int'(rd_addr));
            issue_cyc.push_back(cyc);
            chk("over_issue", m_issued <= m_count, 1);
            chk("outstanding", (m_issued - m_delivered) <= 4, 1);
            m_addr = (m_addr + 1) % 16;
         end
      end
      if (prev_stall) begin
         chk("hold_valid", out_if.out_valid, 1);
         chk("hold_data", out_if.out_data, prev_data);
         chk("hold_last", out_if.out_last, prev_last);
      end
      if (sustain && m_busy && m_delivered > 0 && m_delivered < m_count)
         chk("sustain", out_if.out_valid, 1);
      if (out_if.out_valid) begin
         n_valid++;
         if (!m_busy) chk("valid_idle", out_if.out_valid, 0);
         else begin
            if (!m_first) begin
               m_first = 1;
               chk("first_lat", (cyc - m_accept_cyc) >= 3, 1);
            end
            if (out_if.out_ready) begin
               chk("data", out_if.out_data, word(m_thread, (m_saddr + m_delivered) % 16));
               chk("last", out_if.out_last, (m_delivered + 1 == m_count));
               got_words.push_back(out_if.out_data);
               m_delivered++;
               if (m_delivered == m_count) begin hs_last = 1; last_hs_cyc = cyc; end
            end
         end
      end else begin
         chk("last_wo_valid", out_if.out_last, 0);
      end
      prev_en0   = rd_en0;
      prev_stall = out_if.out_valid & ~out_if.out_ready;
      prev_data  = out_if.out_data;
      prev_last  = out_if.out_last;

      // what the coming clock edge must do
      m_done = 0;
      if (rst) begin
         m_busy = 0; m_after_rst = 1; prev_stall = 0;
      end else begin
         m_after_rst = 0;
         if (hs_last) begin
            m_busy = 0; m_done = 1;
         end else if (!m_busy && start) begin
            n_accept++;
            if (count == 0) m_done = 1;
            else begin
               m_busy = 1; m_thread = int'(thread_num); m_saddr = int'(start_addr);
               m_addr = m_saddr; m_count = int'(count); m_issued = 0; m_delivered = 0;
               m_accept_cyc = cyc; m_first = 0;
               got_addrs.delete(); issue_cyc.delete(); got_words.delete();
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int rmode = 0, pct = 50;   // 0: ready high, 1: random, 2: ready low

   task automatic tick();
      @(posedge clk); #1;
      case (rmode)
         0: out_if.out_ready = 1'b1;
         1: out_if.out_ready = ($urandom_range(0, 99) < pct);
         default: out_if.out_ready = 1'b0;
      endcase
   endtask

   task automatic start_burst(input int t, input int a, input int c);
      thread_num = 3'(t); start_addr = 4'(a); count = 5'(c); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max && m_busy; i++) tick();
      if (m_busy) begin
         chk("timeout", m_busy, 0);
         rst = 1'b1; tick(); rst = 1'b0;
      end
      tick(); tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, d0, e0, v0;
      rst = 1'b1; start = 1'b0; thread_num = '0; start_addr = '0; count = '0;
      out_if.out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("init_busy", busy, 0); chk("init_valid", out_if.out_valid, 0);

      // thread 2, addr 3, count 5, ready high
      rmode = 0; sustain = 1;
      start_burst(2, 3, 5);
      wait_idle(100);
      sustain = 0;
      chk("b1_n", got_words.size(), 5);
      if (got_words.size() == 5 && got_addrs.size() == 5) begin
         chk("b1_w0", got_words[0], 16'h0203);
         chk("b1_w4", got_words[4], 16'h0207);
         for (int i = 0; i < 5; i++) chk("b1_addr", got_addrs[i], 3 + i);
         chk("b1_consec", issue_cyc[4] - issue_cyc[0], 4);
      end
      chk("b1_done_lat", done_cyc - last_hs_cyc, 1);

      // address wrap 14,15,0,1
      start_burst(1, 14, 4);
      wait_idle(100);
      chk("wrap_n", got_addrs.size(), 4);
      if (got_addrs.size() == 4 && got_words.size() == 4) begin
         chk("wrap_a2", got_addrs[2], 0);
         chk("wrap_a3", got_addrs[3], 1);
         chk("wrap_w3", got_words[3], 16'h0101);
      end

      // count 16, consumer stalled 20 cycles then random
      rmode = 2;
      start_burst(1, 5, 16);
      repeat (20) tick();
      chk("stall_issued", m_issued, 4);
      chk("stall_words", got_words.size(), 0);
      rmode = 1; pct = 50;
      wait_idle(400);
      chk("b16_n", got_words.size(), 16);
      if (got_words.size() == 16) chk("b16_w15", got_words[15], 16'h0104);

      // count 0
      rmode = 0;
      e0 = n_en0; v0 = n_valid; d0 = n_done;
      start_burst(3, 5, 0);
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      tick();
      chk("z_done_end", done, 0);
      tick();
      chk("z_en0", n_en0 - e0, 0);
      chk("z_valid", n_valid - v0, 0);
      chk("z_ndone", n_done - d0, 1);

      // reset while the 3rd word is presented
      start_burst(4, 0, 8);
      for (int i = 0; i < 100 && m_delivered < 2; i++) tick();
      d0 = n_done;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("r_valid", out_if.out_valid, 0);
      chk("r_busy", busy, 0);
      repeat (6) tick();
      chk("r_no_done", n_done - d0, 0);
      start_burst(5, 9, 6);
      wait_idle(100);
      chk("r_next_n", got_words.size(), 6);
      if (got_words.size() == 6) chk("r_next_w5", got_words[5], 16'h050E);

      // start held through a burst and into its done cycle
      a0 = n_accept;
      thread_num = 3'd0; start_addr = 4'd2; count = 5'd3; start = 1'b1;
      tick();
      thread_num = 3'd5; start_addr = 4'd10; count = 5'd2;
      for (int i = 0; i < 100 && !m_done; i++) tick();
      tick();
      start = 1'b0;
      chk("held_accepts", n_accept - a0, 2);
      wait_idle(100);
      chk("held_n", got_addrs.size(), 2);
      if (got_addrs.size() == 2 && got_words.size() == 2) begin
         chk("held_a0", got_addrs[0], 10);
         chk("held_w1", got_words[1], 16'h050B);
      end

      // random bursts
      for (int b = 0; b < 30; b++) begin
         rmode = ($urandom_range(0, 3) == 0) ? 0 : 1;
         pct = $urandom_range(15, 100);
         start_burst($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 16));
         wait_idle(800);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
